// File: rtl/grid_cell_renderer.sv
// grid_cell_renderer: queued cell painter for the VGA adapter pixel port.
// Commands enter a small FIFO; an FSM scans each cell one pixel per clock.
module grid_cell_renderer #(
    parameter int ROWS        = 12,
    parameter int COLS        = 12,
    parameter int CELL        = 30,
    parameter int PITCH       = 33,
    parameter int X0          = 214,
    parameter int Y0          = 32,
    parameter int COLOR_DEPTH = 9,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR = 9'h1FF,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic                   vga_sync,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_row,
    input  logic [3:0]             cmd_col,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    input  logic                   cmd_mode,
    input  logic                   clear_req,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic [COLOR_DEPTH-1:0] pix_color,
    output logic                   pix_write,
    output logic                   busy,
    output logic                   err_drop
);

    localparam int         AW     = $clog2(FIFO_DEPTH);
    localparam logic [5:0] LAST   = 6'(CELL - 1);
    localparam logic [3:0] LAST_R = 4'(ROWS - 1);
    localparam logic [3:0] LAST_C = 4'(COLS - 1);
    localparam logic [4:0] NR     = 5'(ROWS);
    localparam logic [4:0] NC     = 5'(COLS);

    typedef struct packed {
        logic [3:0]             row;
        logic [3:0]             col;
        logic [COLOR_DEPTH-1:0] color;
        logic                   mode;
    } cmd_t;

    typedef enum logic [2:0] {
        INIT_WAIT,
        CLEAR,
        IDLE,
        LOAD,
        DRAW
    } state_t;

    state_t state_q, state_d;

    cmd_t        mem_q [FIFO_DEPTH];
    cmd_t        head;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        full, empty, push, pop;

    logic [3:0]             r_q, r_d, c_q, c_d;
    logic [5:0]             dx_q, dx_d, dy_q, dy_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic                   mode_q, mode_d;
    logic                   pend_q, pend_d;

    logic [9:0]             x_q, x_d;
    logic [8:0]             y_q, y_d;
    logic [COLOR_DEPTH-1:0] pcol_q, pcol_d;
    logic                   pw_q, pw_d;
    logic                   err_q, err_d;

    logic scan, cell_end, border;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rd_q[AW-1:0]];

    assign cmd_ready = !full;
    assign busy      = (state_q != IDLE) || !empty;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_color = pcol_q;
    assign pix_write = pw_q;
    assign err_drop  = err_q;

    assign cell_end = (dx_q == LAST) && (dy_q == LAST);
    assign border   = (dx_q == 6'd0) || (dy_q == 6'd0) ||
                      (dx_q == LAST) || (dy_q == LAST);

    // Command storage; stale entries are harmless since reset clears pointers.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= '{cmd_row, cmd_col, cmd_color, cmd_mode};
        end
    end

    // State, scan position, FIFO pointers and registered pixel outputs.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= INIT_WAIT;
            wr_q    <= '0;
            rd_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            color_q <= BG_COLOR;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
            x_q     <= 10'(X0);
            y_q     <= 9'(Y0);
            pcol_q  <= BG_COLOR;
            pw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            r_q     <= r_d;
            c_q     <= c_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            color_q <= color_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pcol_q  <= pcol_d;
            pw_q    <= pw_d;
            err_q   <= err_d;
        end
    end

    // Next-state, scan stepping and pixel generation.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        color_d = color_q;
        mode_d  = mode_q;
        pend_d  = pend_q || clear_req;
        x_d     = x_q;
        y_d     = y_q;
        pcol_d  = pcol_q;
        pw_d    = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        scan    = 1'b0;

        unique case (state_q)
            INIT_WAIT: begin
                r_d  = '0;
                c_d  = '0;
                dx_d = '0;
                dy_d = '0;
                if (vga_sync) state_d = CLEAR;
            end
            IDLE: begin
                dx_d = '0;
                dy_d = '0;
                if (pend_q) begin
                    state_d = CLEAR;
                    r_d     = '0;
                    c_d     = '0;
                    pend_d  = clear_req;
                end else if (!empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                r_d     = head.row;
                c_d     = head.col;
                color_d = head.color;
                mode_d  = head.mode;
                if ({1'b0, head.row} >= NR || {1'b0, head.col} >= NC) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                scan   = 1'b1;
                pw_d   = !mode_q || border;
                pcol_d = color_q;
                if (cell_end) state_d = IDLE;
            end
            CLEAR: begin
                scan   = 1'b1;
                pw_d   = 1'b1;
                pcol_d = BG_COLOR;
                if (cell_end) begin
                    if (c_q == LAST_C) begin
                        c_d = '0;
                        r_d = r_q + 4'd1;
                        if (r_q == LAST_R) state_d = IDLE;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            default: state_d = INIT_WAIT;
        endcase

        if (scan) begin
            x_d = 10'(11'(X0) + 11'(c_q) * 11'(PITCH) + 11'(dx_q));
            y_d = 9'(10'(Y0) + 10'(r_q) * 10'(PITCH) + 10'(dy_q));
            if (dx_q == LAST) begin
                dx_d = '0;
                dy_d = (dy_q == LAST) ? 6'd0 : dy_q + 6'd1;
            end else begin
                dx_d = dx_q + 6'd1;
            end
        end
    end

    assign wr_d = wr_q + (AW+1)'(push);
    assign rd_d = rd_q + (AW+1)'(pop);

endmodule

// File: tb/tb_grid_cell_renderer.sv
// Self-checking bench for grid_cell_renderer on a reduced 3x4 grid of 5 px cells.
// A pixel-list model predicts every write in order from the drawing rules.
module tb_grid_cell_renderer;

    localparam int R  = 3;
    localparam int C  = 4;
    localparam int CL = 5;
    localparam int P  = 7;
    localparam int XO = 20;
    localparam int YO = 10;
    localparam int BG = 'h1FF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vga_sync = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_row = '0;
    logic [3:0] cmd_col = '0;
    logic [8:0] cmd_color = '0;
    logic       cmd_mode = 1'b0;
    logic       clear_req = 1'b0;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [8:0] pix_color;
    logic       pix_write;
    logic       busy;
    logic       err_drop;

    grid_cell_renderer #(
        .ROWS(R), .COLS(C), .CELL(CL), .PITCH(P), .X0(XO), .Y0(YO),
        .COLOR_DEPTH(9), .BG_COLOR(9'h1FF), .FIFO_DEPTH(8)
    ) dut (
        .CLOCK_50(clk), .Reset(rst), .vga_sync(vga_sync),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_color(cmd_color),
        .cmd_mode(cmd_mode), .clear_req(clear_req),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_write(pix_write), .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int col; } pix_t;
    typedef struct {
        int row; int col; int color; bit mode;
        int exp_w; int exp_e; int exp_cyc;
    } vec_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   writes   = 0;
    int   errs     = 0;
    bit   err_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_cell(input int r, input int c, input int col, input bit mode);
        if (r >= R || c >= C) return;
        for (int dy = 0; dy < CL; dy++)
            for (int dx = 0; dx < CL; dx++)
                if (!mode || dx == 0 || dy == 0 || dx == CL-1 || dy == CL-1)
                    exp_q.push_back('{XO + c*P + dx, YO + r*P + dy, col});
    endtask

    task automatic expect_clear();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                expect_cell(r, c, BG, 1'b0);
    endtask

    // Pixel monitor: each write must match the next predicted pixel.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_write) begin
                writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", int'({pix_x, pix_y, pix_color}), -1);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pixel", int'({pix_x, pix_y, pix_color}),
                        (e.x << 18) | (e.y << 9) | e.col);
                end
            end
            if (err_drop) begin
                errs++;
                chk("err_width", int'(err_prev), 0);
            end
            err_prev = err_drop;
        end
    end

    task automatic wait_idle(input int max, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (busy && k < max);
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_writes(input int n, input int max);
        int k;
        k = 0;
        while (writes < n && k < max) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (writes < n) chk("write_timeout", writes, n);
    endtask

    task automatic push_cmd(input int r, input int c, input int col, input bit mode);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_row   = 4'(r);
        cmd_col   = 4'(c);
        cmd_color = 9'(col);
        cmd_mode  = mode;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        expect_cell(r, c, col, mode);
    endtask

    vec_t tbl[7];

    initial begin
        int k, w0, e0, lat, exp_err;
        bit seen;

        tbl[0] = '{2, 3, 7,     1'b0, 25, 0, 27};
        tbl[1] = '{2, 3, 'h1C0, 1'b1, 16, 0, 27};
        tbl[2] = '{0, 0, 'h0AA, 1'b0, 25, 0, 27};
        tbl[3] = '{1, 2, 'h055, 1'b1, 16, 0, 27};
        tbl[4] = '{3, 0, 'h100, 1'b0, 0,  1, 2};
        tbl[5] = '{0, 4, 'h0F0, 1'b0, 0,  1, 2};
        tbl[6] = '{15, 15, 'h00F, 1'b1, 0, 1, 2};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_x", int'(pix_x), XO);
        chk("rst_pix_y", int'(pix_y), YO);
        chk("rst_pix_color", int'(pix_color), BG);
        chk("rst_pix_write", int'(pix_write), 0);
        chk("rst_err_drop", int'(err_drop), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Initial clear waits for vga_sync.
        repeat (50) @(posedge clk);
        #1;
        chk("init_wait_writes", writes, 0);
        chk("init_wait_busy", int'(busy), 1);
        @(negedge clk);
        vga_sync = 1'b1;
        expect_clear();
        wait_idle(2000, k);
        @(negedge clk);
        #1;
        chk("init_clear_writes", writes, R*C*CL*CL);
        chk("init_clear_left", exp_q.size(), 0);

        // First-write latency and last-pixel timing.
        push_cmd(1, 0, 'h033, 1'b0);
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (pix_write && !seen) begin
                lat = i;
                seen = 1'b1;
            end
            if (i == 2 + CL*CL) chk("last_pixel_on", int'(pix_write), 1);
            if (i == 3 + CL*CL) chk("after_last_off", int'(pix_write), 0);
        end
        chk("first_write_latency", lat, 3);
        chk("latency_left", exp_q.size(), 0);

        // Table of single commands.
        foreach (tbl[i]) begin
            w0 = writes;
            e0 = errs;
            push_cmd(tbl[i].row, tbl[i].col, tbl[i].color, tbl[i].mode);
            wait_idle(200, k);
            chk("vec_cycles", k, tbl[i].exp_cyc);
            @(negedge clk);
            #1;
            chk("vec_writes", writes - w0, tbl[i].exp_w);
            chk("vec_errs", errs - e0, tbl[i].exp_e);
            chk("vec_left", exp_q.size(), 0);
        end

        // Error drop followed by a good command.
        w0 = writes;
        e0 = errs;
        push_cmd(3, 0, 'h111, 1'b0);
        push_cmd(1, 1, 'h022, 1'b0);
        wait_idle(200, k);
        @(negedge clk);
        #1;
        chk("drop_errs", errs - e0, 1);
        chk("drop_writes", writes - w0, CL*CL);
        chk("drop_left", exp_q.size(), 0);

        // Fill the FIFO while a clear keeps the FSM occupied.
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        expect_clear();
        for (int i = 0; i < 8; i++) begin
            chk("ready_not_full", int'(cmd_ready), 1);
            cmd_valid = 1'b1;
            cmd_row   = 4'(i % R);
            cmd_col   = 4'(i % C);
            cmd_color = 9'(i * 11 + 1);
            cmd_mode  = 1'(i % 2);
            @(posedge clk);
            expect_cell(i % R, i % C, i * 11 + 1, 1'(i % 2));
            @(negedge clk);
        end
        cmd_row   = 4'd2;
        cmd_col   = 4'd1;
        cmd_color = 9'h0C3;
        cmd_mode  = 1'b0;
        chk("ready_full", int'(cmd_ready), 0);
        k = 0;
        while (!cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("ready_return", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        expect_cell(2, 1, 'h0C3, 1'b0);
        wait_idle(3000, k);
        @(negedge clk);
        #1;
        chk("fifo_order_left", exp_q.size(), 0);

        // Randomized commands with random gaps.
        e0 = errs;
        exp_err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_row   = 4'($urandom_range(0, R));
            cmd_col   = 4'($urandom_range(0, C));
            cmd_color = 9'($urandom_range(0, 511));
            cmd_mode  = 1'($urandom_range(0, 1));
            if (cmd_valid && cmd_ready) begin
                if (int'(cmd_row) >= R || int'(cmd_col) >= C) exp_err++;
                expect_cell(int'(cmd_row), int'(cmd_col), int'(cmd_color), cmd_mode);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(8000, k);
        @(negedge clk);
        #1;
        chk("rand_left", exp_q.size(), 0);
        chk("rand_errs", errs - e0, exp_err);

        // Clear mid-draw, then reset mid-clear.
        w0 = writes;
        push_cmd(1, 1, 'h0E0, 1'b0);
        wait_writes(w0 + 5, 200);
        @(negedge clk);
        clear_req = 1'b1;
        expect_clear();
        @(negedge clk);
        clear_req = 1'b0;
        wait_writes(w0 + CL*CL + 10, 400);
        @(posedge clk);
        #1;
        chk("midclear_write", int'(pix_write), 1);
        rst = 1'b1;
        vga_sync = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_write_drop", int'(pix_write), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        w0 = writes;
        repeat (10) @(posedge clk);
        #1;
        chk("reinit_writes", writes - w0, 0);
        chk("reinit_busy", int'(busy), 1);
        @(negedge clk);
        vga_sync = 1'b1;
        expect_clear();
        wait_idle(2000, k);
        @(negedge clk);
        #1;
        chk("reclear_writes", writes - w0, R*C*CL*CL);
        chk("reclear_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
